// File: rtl/decode_stage.sv
// Decode stage of the 5-stage ARM pipeline.
// Holds the architectural register file and selects the two read addresses.
// Extends the immediate field and registers everything into the D/E register.
module decode_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             pipeEnable,
    input  logic             flushE,
    input  logic [31:0]      instD,
    input  logic [WIDTH-1:0] pcPlus8D,
    input  logic             regWriteW,
    input  logic [3:0]       wa3W,
    input  logic [WIDTH-1:0] resultW,
    output logic [3:0]       ra1D,
    output logic [3:0]       ra2D,
    output logic             validE,
    output logic [WIDTH-1:0] rd1E,
    output logic [WIDTH-1:0] rd2E,
    output logic [WIDTH-1:0] extImmE,
    output logic [3:0]       wa3E,
    output logic [3:0]       condE,
    output logic [1:0]       opE,
    output logic [5:0]       functE
);

    localparam logic [3:0] PC_REG = 4'hF;

    logic [WIDTH-1:0] regs_r [NREGS];

    logic [1:0]       op_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;
    logic [WIDTH-1:0] ext_imm_s;

    assign op_s = instD[27:26];

    // Rotate a value right by amt bits, wrapping modulo the data width.
    function automatic logic [WIDTH-1:0] ror_val(input logic [WIDTH-1:0] val,
                                                 input logic [4:0]       amt);
        logic [2*WIDTH-1:0] dbl;
        dbl = {val, val} >> amt;
        return dbl[WIDTH-1:0];
    endfunction

    // Combinational register read: R15 aliases PC+8, then same-cycle
    // writeback bypass, then the stored entry.
    function automatic logic [WIDTH-1:0] read_reg(input logic [3:0]       addr,
                                                  input logic [WIDTH-1:0] stored);
        logic [WIDTH-1:0] val;
        if (addr == PC_REG) begin
            val = pcPlus8D;
        end else if (regWriteW && (wa3W == addr)) begin
            val = resultW;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Read-address selection: branches use R15 as base, stores read Rd as data.
    always_comb begin
        ra1D = instD[19:16];
        ra2D = instD[3:0];
        if (op_s == 2'b10) begin
            ra1D = PC_REG;
        end else begin
            ra1D = instD[19:16];
        end
        if (op_s == 2'b01) begin
            ra2D = instD[15:12];
        end else begin
            ra2D = instD[3:0];
        end
    end

    // Read data for both ports.
    always_comb begin
        rd1_s = read_reg(ra1D, regs_r[ra1D]);
        rd2_s = read_reg(ra2D, regs_r[ra2D]);
    end

    // Immediate extension selected by the op field.
    always_comb begin
        ext_imm_s = {WIDTH{1'b0}};
        case (op_s)
            2'b00: ext_imm_s = ror_val({{(WIDTH-8){1'b0}}, instD[7:0]},
                                       {instD[11:8], 1'b0});
            2'b01: ext_imm_s = {{(WIDTH-12){1'b0}}, instD[11:0]};
            2'b10: ext_imm_s = {{(WIDTH-24){instD[23]}}, instD[23:0]} << 2;
            2'b11: ext_imm_s = {WIDTH{1'b0}};
            default: ext_imm_s = {WIDTH{1'b0}};
        endcase
    end

    // Register file write; R15 writes are dropped because fetch owns the PC.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (regWriteW && (wa3W != PC_REG)) begin
            regs_r[wa3W] <= resultW;
        end
    end

    // D/E pipeline register: reset, then flush (beats stall), then load, else hold.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            validE  <= 1'b0;
            rd1E    <= {WIDTH{1'b0}};
            rd2E    <= {WIDTH{1'b0}};
            extImmE <= {WIDTH{1'b0}};
            wa3E    <= 4'h0;
            condE   <= 4'h0;
            opE     <= 2'b00;
            functE  <= 6'h00;
        end else if (flushE) begin
            validE  <= 1'b0;
            rd1E    <= {WIDTH{1'b0}};
            rd2E    <= {WIDTH{1'b0}};
            extImmE <= {WIDTH{1'b0}};
            wa3E    <= 4'h0;
            condE   <= 4'h0;
            opE     <= 2'b00;
            functE  <= 6'h00;
        end else if (pipeEnable) begin
            validE  <= 1'b1;
            rd1E    <= rd1_s;
            rd2E    <= rd2_s;
            extImmE <= ext_imm_s;
            wa3E    <= instD[15:12];
            condE   <= instD[31:28];
            opE     <= op_s;
            functE  <= instD[25:20];
        end else begin
            validE  <= validE;
            rd1E    <= rd1E;
            rd2E    <= rd2E;
            extImmE <= extImmE;
            wa3E    <= wa3E;
            condE   <= condE;
            opE     <= opE;
            functE  <= functE;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;

    logic        clock;
    logic        rst;
    logic        pipeEnable;
    logic        flushE;
    logic [31:0] instD;
    logic [31:0] pcPlus8D;
    logic        regWriteW;
    logic [3:0]  wa3W;
    logic [31:0] resultW;
    logic [3:0]  ra1D;
    logic [3:0]  ra2D;
    logic        validE;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] extImmE;
    logic [3:0]  wa3E;
    logic [3:0]  condE;
    logic [1:0]  opE;
    logic [5:0]  functE;

    int tests_run    = 0;
    int tests_failed = 0;

    decode_stage #(.WIDTH(32), .NREGS(16)) dut (
        .clock      (clock),
        .rst        (rst),
        .pipeEnable (pipeEnable),
        .flushE     (flushE),
        .instD      (instD),
        .pcPlus8D   (pcPlus8D),
        .regWriteW  (regWriteW),
        .wa3W       (wa3W),
        .resultW    (resultW),
        .ra1D       (ra1D),
        .ra2D       (ra2D),
        .validE     (validE),
        .rd1E       (rd1E),
        .rd2E       (rd2E),
        .extImmE    (extImmE),
        .wa3E       (wa3E),
        .condE      (condE),
        .opE        (opE),
        .functE     (functE)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for every check.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        pipeEnable = 1'b0;
        flushE     = 1'b0;
        instD      = 32'h0000_0000;
        pcPlus8D   = 32'h0000_0008;
        regWriteW  = 1'b0;
        wa3W       = 4'h0;
        resultW    = 32'h0000_0000;

        // Reset state
        step();
        check_val("rst_validE", {31'd0, validE}, 32'd0);
        check_val("rst_rd1E", rd1E, 32'd0);
        check_val("rst_extImmE", extImmE, 32'd0);
        rst = 1'b0;

        // 1: write R3, then ADD R0,R1,R3
        regWriteW = 1'b1; wa3W = 4'd3; resultW = 32'hDEAD_BEEF;
        step();
        regWriteW = 1'b0;
        instD = 32'hE081_0003; pipeEnable = 1'b1;
        #1;
        check_val("add_ra1D", {28'd0, ra1D}, 32'd1);
        check_val("add_ra2D", {28'd0, ra2D}, 32'd3);
        step();
        check_val("add_rd2E", rd2E, 32'hDEAD_BEEF);
        check_val("add_rd1E", rd1E, 32'd0);
        check_val("add_wa3E", {28'd0, wa3E}, 32'd0);
        check_val("add_opE", {30'd0, opE}, 32'd0);
        check_val("add_validE", {31'd0, validE}, 32'd1);
        check_val("add_condE", {28'd0, condE}, 32'hE);
        check_val("add_functE", {26'd0, functE}, 32'h08);
        check_val("add_extImmE", extImmE, 32'h3);

        // 2: same-cycle bypass of R5, then stored value
        instD = 32'hE081_0005;
        regWriteW = 1'b1; wa3W = 4'd5; resultW = 32'h1234_5678;
        step();
        check_val("byp_rd2E", rd2E, 32'h1234_5678);
        regWriteW = 1'b0; resultW = 32'h0;
        step();
        check_val("stored_rd2E", rd2E, 32'h1234_5678);

        // 3: branch reads R15, sign-extended shifted immediate
        pcPlus8D = 32'h0000_0108; instD = 32'hEAFF_FFFE;
        #1;
        check_val("b_ra1D", {28'd0, ra1D}, 32'hF);
        check_val("b_ra2D", {28'd0, ra2D}, 32'hE);
        step();
        check_val("b_rd1E", rd1E, 32'h0000_0108);
        check_val("b_extImmE", extImmE, 32'hFFFF_FFF8);
        check_val("b_opE", {30'd0, opE}, 32'd2);
        check_val("b_functE", {26'd0, functE}, 32'h2F);
        check_val("b_wa3E", {28'd0, wa3E}, 32'hF);

        // 4: rotated immediates, LDR zero-extend, op 11
        instD = 32'hE3A0_04FF; step();
        check_val("rot4_extImmE", extImmE, 32'hFF00_0000);
        check_val("rot4_functE", {26'd0, functE}, 32'h3A);
        instD = 32'hE3A0_0FFF; step();
        check_val("rot15_extImmE", extImmE, 32'h0000_03FC);
        instD = 32'hE3A0_0001; step();
        check_val("rot0_extImmE", extImmE, 32'h0000_0001);
        instD = 32'hE591_20AC;
        #1;
        check_val("ldr_ra1D", {28'd0, ra1D}, 32'd1);
        check_val("ldr_ra2D", {28'd0, ra2D}, 32'd2);
        step();
        check_val("ldr_extImmE", extImmE, 32'h0000_00AC);
        check_val("ldr_opE", {30'd0, opE}, 32'd1);
        instD = 32'hEC00_0123; step();
        check_val("op3_extImmE", extImmE, 32'd0);
        check_val("op3_opE", {30'd0, opE}, 32'd3);

        // 5: load, stall two cycles, then flush during stall
        instD = 32'hE081_0005; step();
        pipeEnable = 1'b0; instD = 32'hEAFF_FFFE;
        step(); step();
        check_val("stall_rd2E", rd2E, 32'h1234_5678);
        check_val("stall_extImmE", extImmE, 32'h5);
        check_val("stall_opE", {30'd0, opE}, 32'd0);
        check_val("stall_validE", {31'd0, validE}, 32'd1);
        check_val("stall_condE", {28'd0, condE}, 32'hE);
        flushE = 1'b1; step();
        check_val("flush_validE", {31'd0, validE}, 32'd0);
        check_val("flush_rd2E", rd2E, 32'd0);
        check_val("flush_extImmE", extImmE, 32'd0);
        check_val("flush_condE", {28'd0, condE}, 32'd0);
        check_val("flush_functE", {26'd0, functE}, 32'd0);
        flushE = 1'b0; pipeEnable = 1'b1; instD = 32'hE081_0005; step();
        check_val("reload_rd2E", rd2E, 32'h1234_5678);
        check_val("reload_validE", {31'd0, validE}, 32'd1);

        // 6: asynchronous reset between edges, then R15 write ignored
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_validE", {31'd0, validE}, 32'd0);
        check_val("arst_rd2E", rd2E, 32'd0);
        check_val("arst_condE", {28'd0, condE}, 32'd0);
        rst = 1'b0;
        step();
        regWriteW = 1'b1; wa3W = 4'hF; resultW = 32'hAAAA_5555;
        pcPlus8D = 32'h0000_0200; instD = 32'hEAFF_FFFE;
        step();
        check_val("r15_byp_rd1E", rd1E, 32'h0000_0200);
        regWriteW = 1'b0; instD = 32'hEAFF_FFFE; pcPlus8D = 32'h0000_0300;
        step();
        check_val("r15_rd1E", rd1E, 32'h0000_0300);
        instD = 32'hE081_0005; step();
        check_val("arst_r5_rd2E", rd2E, 32'd0);
        instD = 32'hE081_0003; step();
        check_val("arst_r3_rd2E", rd2E, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
